// File: rtl/periph_poll_pkg.sv
// Shared types and constants for the polled-peripheral arbiter.
// Optional timeout feature is enabled with the PPA_TIMEOUT_EN macro.
package periph_poll_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_STAT_RD   = 3'd1,
      ST_STAT_WAIT = 3'd2,
      ST_DATA_RD   = 3'd3,
      ST_DATA_WAIT = 3'd4,
      ST_ACK       = 3'd5,
      ST_RESP      = 3'd6
   } state_e;

   localparam int unsigned STATUS_READY_BIT = 0;
   localparam logic        SEL_STATUS       = 1'b0;
   localparam logic        SEL_DATA         = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: one-hot pointer register plus
// combinational first-requester-at-or-after-pointer search.
module rr_arbiter #(
   parameter int unsigned NREQ = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            upd,
   input  logic [NREQ-1:0] cur_gnt,
   output logic [NREQ-1:0] nxt_gnt_c
);

   localparam int unsigned IW = $clog2(NREQ);

   logic [NREQ-1:0] ptr;
   logic [IW-1:0]   start_c;
   logic [IW:0]     idx_c;
   logic            found_c;

   // Pointer moves to the slot just after the requester that was served
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= NREQ'(1);
      end else if (upd) begin
         ptr <= {cur_gnt[NREQ-2:0], cur_gnt[NREQ-1]};
      end
   end

   // First active request searching upward from the pointer, wrapping
   always_comb begin
      nxt_gnt_c = '0;
      start_c   = '0;
      idx_c     = '0;
      found_c   = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (ptr[i]) start_c = IW'(i);
      end
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx_c = {1'b0, start_c} + (IW+1)'(k);
         if (idx_c >= (IW+1)'(NREQ)) idx_c = idx_c - (IW+1)'(NREQ);
         if (!found_c && req[idx_c[IW-1:0]]) begin
            nxt_gnt_c[idx_c[IW-1:0]] = 1'b1;
            found_c                  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/periph_poll_arbiter.sv
// Shares one polled status/data peripheral among NREQ requesters.
// Per grant: poll status until ready, read data, ack the peripheral,
// return the word. Define PPA_TIMEOUT_EN to bound polling at TO_POLLS.
module periph_poll_arbiter
   import periph_poll_pkg::*;
#(
   parameter int unsigned NREQ     = 2,
   parameter int unsigned DW       = 16,
   parameter int unsigned TO_POLLS = 1000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic            rsp_valid,
   output logic [DW-1:0]   rsp_data,
   output logic            rsp_err,
   output logic            periph_sel,
   output logic            periph_rd,
   input  logic [DW-1:0]   periph_rdata,
   output logic            periph_ack,
   output logic            busy
);

   if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
      $error("periph_poll_arbiter: NREQ must be 2..8");
   end
   if (TO_POLLS < 1) begin : g_to_chk
      $error("periph_poll_arbiter: TO_POLLS must be at least 1");
   end

   state_e          state, next_state;
   logic [NREQ-1:0] gnt_d;
   logic [DW-1:0]   rsp_data_d;
   logic [NREQ-1:0] arb_gnt_c;
   logic            arb_upd_c;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .upd       (arb_upd_c),
      .cur_gnt   (gnt),
      .nxt_gnt_c (arb_gnt_c)
   );

`ifdef PPA_TIMEOUT_EN
   localparam int unsigned PCW = $clog2(TO_POLLS + 1);

   logic [PCW-1:0] poll_cnt, poll_cnt_d, poll_inc_c;
   logic           rsp_err_d;

   assign poll_inc_c = (poll_cnt == '1) ? poll_cnt : poll_cnt + PCW'(1);

   // Not-ready poll counter, saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         poll_cnt <= '0;
         rsp_err  <= 1'b0;
      end else begin
         poll_cnt <= poll_cnt_d;
         rsp_err  <= rsp_err_d;
      end
   end
`else
   assign rsp_err = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // Next-state, grant and captured-data logic
   always_comb begin
      next_state = state;
      gnt_d      = gnt;
      rsp_data_d = rsp_data;
      arb_upd_c  = 1'b0;
`ifdef PPA_TIMEOUT_EN
      poll_cnt_d = poll_cnt;
      rsp_err_d  = 1'b0;
`endif
      unique case (state)
         ST_IDLE: begin
            if (|req) begin
               gnt_d      = arb_gnt_c;
               next_state = ST_STAT_RD;
`ifdef PPA_TIMEOUT_EN
               poll_cnt_d = '0;
`endif
            end
         end
         ST_STAT_RD:   next_state = ST_STAT_WAIT;
         ST_STAT_WAIT: begin
            if (periph_rdata[STATUS_READY_BIT]) begin
               next_state = ST_DATA_RD;
            end else begin
`ifdef PPA_TIMEOUT_EN
               poll_cnt_d = poll_inc_c;
               if (poll_inc_c == PCW'(TO_POLLS)) begin
                  next_state = ST_RESP;
                  rsp_err_d  = 1'b1;
                  rsp_data_d = '0;
               end else begin
                  next_state = ST_STAT_RD;
               end
`else
               next_state = ST_STAT_RD;
`endif
            end
         end
         ST_DATA_RD:   next_state = ST_DATA_WAIT;
         ST_DATA_WAIT: begin
            rsp_data_d = periph_rdata;
            next_state = ST_ACK;
         end
         ST_ACK:       next_state = ST_RESP;
         ST_RESP: begin
            arb_upd_c  = 1'b1;
            gnt_d      = '0;
            next_state = ST_IDLE;
         end
         default:      next_state = ST_IDLE;
      endcase
   end

   // Registered outputs, decoded from the state being entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt        <= '0;
         rsp_data   <= '0;
         rsp_valid  <= 1'b0;
         periph_sel <= SEL_STATUS;
         periph_rd  <= 1'b0;
         periph_ack <= 1'b0;
         busy       <= 1'b0;
      end else begin
         gnt        <= gnt_d;
         rsp_data   <= rsp_data_d;
         rsp_valid  <= (next_state == ST_RESP);
         periph_sel <= (next_state == ST_DATA_RD) ? SEL_DATA : SEL_STATUS;
         periph_rd  <= (next_state == ST_STAT_RD) || (next_state == ST_DATA_RD);
         periph_ack <= (next_state == ST_ACK);
         busy       <= (next_state != ST_IDLE);
      end
   end

endmodule

// File: doc/periph_poll_arbiter.md
# periph_poll_arbiter

Sequences and shares one status/data peripheral (timer/keypad style: status word with a ready bit, data word, one-cycle ack) among NREQ requesters. Grants are round-robin; for each grant the block polls status until ready, reads data, pulses ack to the peripheral, and returns the word to the granted requester. It sits between the peripheral's read port and the consumers that previously polled the peripheral directly.

## Interface
- NREQ, 2, number of requesters (2..8)
- DW, 16, peripheral data width
- TO_POLLS, 1000, not-ready status samples before timeout (used only with PPA_TIMEOUT_EN)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  level request per requester
- gnt  out  NREQ  one-hot grant, held for the whole transaction
- rsp_valid  out  1  one-cycle response strobe to granted requester
- rsp_data  out  DW  returned data word, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- periph_sel  out  1  0 = status word, 1 = data word
- periph_rd  out  1  one-cycle read strobe
- periph_rdata  in  DW  read data, valid the cycle after periph_rd
- periph_ack  out  1  one-cycle consume pulse to peripheral
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, STAT_RD, STAT_WAIT, DATA_RD, DATA_WAIT, ACK, RESP.
- IDLE: if any req bit set, round-robin pick (search starts at pointer), register gnt, clear poll count -> STAT_RD.
- STAT_RD: periph_sel=0, periph_rd=1 -> STAT_WAIT.
- STAT_WAIT: periph_rdata[0]=1 -> DATA_RD; else increment poll count -> STAT_RD (timeout check per Configuration).
- DATA_RD: periph_sel=1, periph_rd=1 -> DATA_WAIT.
- DATA_WAIT: register periph_rdata into rsp_data -> ACK.
- ACK: periph_ack=1 -> RESP.
- RESP: rsp_valid=1; pointer = granted index + 1 (mod NREQ) -> IDLE, gnt cleared on exit.
- periph_sel is 0 except in DATA_RD; rsp_data holds last value until next capture.
- Requester dropping req after grant: ignored, transaction completes (data already consumed must be acked).
- Requester must drop req the cycle after rsp_valid or it is treated as a new request.
- Poll count saturates; width clog2(TO_POLLS+1).

## Timing
- Reset values: gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, periph_sel=0, periph_rd=0, periph_ack=0, busy=0, pointer=0, state IDLE.
- All outputs registered/decoded from state; no combinational path req -> outputs.
- req seen in IDLE at cycle 0: gnt and periph_rd at 1, status sampled 2, data rd 3, capture 4, periph_ack 5, rsp_valid 6.
- Each not-ready poll adds 2 cycles; back-to-back transactions: next gnt the cycle after RESP + 1 (IDLE visited once).
- Reset mid-transaction: all outputs drop immediately; no ack emitted; pointer returns to 0.

## Configuration
- PPA_TIMEOUT_EN defined: in STAT_WAIT, when incremented poll count equals TO_POLLS -> RESP with rsp_err=1, rsp_data=0; no data read, no periph_ack.
- Undefined: polling is unbounded, rsp_err tied 0, TO_POLLS unused, no timeout logic.

## Structure
- Package periph_poll_pkg: state enum, STATUS_READY_BIT=0, SEL_STATUS=0, SEL_DATA=1.
- Sub-module rr_arbiter: NREQ-wide pointer register plus one-hot next-grant logic; pointer update input driven from RESP.

## Test plan
- req=01, status ready first poll, data 16'h002A -> gnt=01 at cycle 1, periph_ack at 5 only, rsp_valid at 6 with rsp_data=16'h002A, rsp_err=0.
- req=01, status ready on third poll -> periph_rd at cycles 1,3,5, data rd 7, periph_ack 9, rsp_valid 10.
- req=11 held continuously after reset -> grant order 0,1,0,1; gnt never multi-hot.
- PPA_TIMEOUT_EN, TO_POLLS=4, status never ready -> rsp_valid at cycle 9, rsp_err=1, rsp_data=0, periph_ack never asserted.
- rst_n low during DATA_WAIT -> all outputs 0 same cycle, no ack; after release req=10 served first with gnt=10.
- req0 dropped at cycle 2 -> transaction completes, rsp_valid at 6, then IDLE with gnt=0.
